// File: rtl/aibcr3_dll_cal_pkg.sv
// Shared definitions for the DLL lock / DCC calibration sequencer:
// the FSM state encoding, the DLL reset hold length and the default widths.
package aibcr3_dll_cal_pkg;

  localparam int DEF_LOCK_TMO_W = 12;
  localparam int DEF_SETTLE_W   = 4;
  localparam int DEF_RETRY_W    = 2;

  // Number of cycles the DLL is held in reset on every attempt.
  localparam int DLL_RST_CYC = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DLL_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_DONE      = 3'd4,
    ST_FAIL      = 3'd5
  } cal_state_e;

endpackage

// File: rtl/aibcr3_dll_lock_sync.sv
// Two-flop synchronizer that brings the raw DLL lock indication into the
// clk_dcd domain; both flops clear on the synchronous active-low reset.
module aibcr3_dll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      q        <= 1'b0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/aibcr3_dll_cal_seq.sv
// DLL lock / DCC calibration sequencer: resets the DLL, waits for lock with
// timeout and bounded retries, requires a settle interval, then flags done.
module aibcr3_dll_cal_seq
  import aibcr3_dll_cal_pkg::*;
#(
  parameter int LOCK_TMO_W = DEF_LOCK_TMO_W,
  parameter int SETTLE_W   = DEF_SETTLE_W,
  parameter int RETRY_W    = DEF_RETRY_W
) (
  input  logic                  clk_dcd,
  input  logic                  RSTb,
  input  logic                  cal_start,
  input  logic                  dll_lock_mux,
  input  logic                  rb_cont_cal,
  input  logic [SETTLE_W-1:0]   rb_settle_dly,
  input  logic [LOCK_TMO_W-1:0] rb_lock_tmo,
  input  logic [RETRY_W-1:0]    rb_max_retry,
  output logic                  dll_rst_n,
  output logic                  dcc_done,
  output logic                  dll_lock_reg,
  output logic                  cal_fail,
  output logic [RETRY_W-1:0]    retry_cnt,
  output logic                  busy
);

  // The timer doubles as the DLL reset hold counter while in ST_DLL_RST.
  localparam logic [LOCK_TMO_W-1:0] RST_LAST = LOCK_TMO_W'(DLL_RST_CYC - 1);

  cal_state_e            state_reg, state_next;
  logic [LOCK_TMO_W-1:0] timer_reg, timer_next;
  logic [SETTLE_W-1:0]   settle_reg, settle_next;
  logic [RETRY_W-1:0]    retry_reg, retry_next;
  logic                  lock_s;

  aibcr3_dll_lock_sync u_lock_sync (
    .clk   (clk_dcd),
    .rst_n (RSTb),
    .d     (dll_lock_mux),
    .q     (lock_s)
  );

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    settle_next = settle_reg;
    retry_next  = retry_reg;
    if (!cal_start) begin
      state_next  = ST_IDLE;
      timer_next  = '0;
      settle_next = '0;
      retry_next  = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_DLL_RST;
          timer_next = '0;
          retry_next = '0;
        end
        ST_DLL_RST: begin
          if (timer_reg == RST_LAST) begin
            state_next = ST_WAIT_LOCK;
            timer_next = '0;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock takes precedence over a timeout landing on the same edge.
          if (lock_s) begin
            state_next  = ST_SETTLE;
            settle_next = '0;
          end else if (rb_lock_tmo != '0 && timer_reg == rb_lock_tmo) begin
            timer_next = '0;
            if (retry_reg == rb_max_retry) begin
              state_next = ST_FAIL;
            end else begin
              state_next = ST_DLL_RST;
              retry_next = retry_reg + 1'b1;
            end
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!lock_s) begin
            state_next = ST_WAIT_LOCK;
            timer_next = '0;
          end else if (settle_reg == rb_settle_dly) begin
            state_next = ST_DONE;
          end else begin
            settle_next = settle_reg + 1'b1;
          end
        end
        ST_DONE: begin
          // In continuous-calibration mode a lock loss after done is masked.
          if (!lock_s && !rb_cont_cal) begin
            state_next = ST_WAIT_LOCK;
            timer_next = '0;
          end
        end
        ST_FAIL: begin
          state_next = ST_FAIL;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_dcd) begin
    if (!RSTb) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= '0;
      settle_reg   <= '0;
      retry_reg    <= '0;
      dll_rst_n    <= 1'b0;
      dcc_done     <= 1'b0;
      dll_lock_reg <= 1'b0;
      cal_fail     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      settle_reg   <= settle_next;
      retry_reg    <= retry_next;
      dll_rst_n    <= state_next inside {ST_WAIT_LOCK, ST_SETTLE, ST_DONE};
      dcc_done     <= state_next == ST_DONE;
      dll_lock_reg <= lock_s & ~rb_cont_cal;
      cal_fail     <= state_next == ST_FAIL;
      busy         <= state_next inside {ST_DLL_RST, ST_WAIT_LOCK, ST_SETTLE};
    end
  end

  assign retry_cnt = retry_reg;

endmodule

// File: tb/tb_aibcr3_dll_cal_seq.sv
// Bench for the calibration sequencer: directed corner scenarios plus random
// lock waveforms, all checked every cycle against a deadline-based model.
module tb_aibcr3_dll_cal_seq;

  logic        clk_dcd = 1'b0;
  logic        RSTb = 1'b0;
  logic        cal_start = 1'b0;
  logic        dll_lock_mux = 1'b0;
  logic        rb_cont_cal = 1'b0;
  logic [3:0]  rb_settle_dly = 4'd0;
  logic [11:0] rb_lock_tmo = 12'd0;
  logic [1:0]  rb_max_retry = 2'd0;
  logic        dll_rst_n, dcc_done, dll_lock_reg, cal_fail, busy;
  logic [1:0]  retry_cnt;

  aibcr3_dll_cal_seq dut (
    .clk_dcd       (clk_dcd),
    .RSTb          (RSTb),
    .cal_start     (cal_start),
    .dll_lock_mux  (dll_lock_mux),
    .rb_cont_cal   (rb_cont_cal),
    .rb_settle_dly (rb_settle_dly),
    .rb_lock_tmo   (rb_lock_tmo),
    .rb_max_retry  (rb_max_retry),
    .dll_rst_n     (dll_rst_n),
    .dcc_done      (dcc_done),
    .dll_lock_reg  (dll_lock_reg),
    .cal_fail      (cal_fail),
    .retry_cnt     (retry_cnt),
    .busy          (busy)
  );

  always #5 clk_dcd = ~clk_dcd;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: phase plus the edge number it was entered on; every
  // exit is a deadline measured from that entry edge.
  localparam int M_IDLE = 0, M_RST = 1, M_WAIT = 2, M_SETTLE = 3, M_DONE = 4, M_FAIL = 5;
  int       mode = M_IDLE;
  int       t_enter = 0;
  int       cyc = 0;
  logic [1:0] m_retry = 2'd0;
  logic     m1 = 1'b0, m2 = 1'b0, m_lockreg = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic lk;
    int   nm;
    cyc++;
    if (!RSTb) begin
      mode = M_IDLE; m_retry = 2'd0; m1 = 1'b0; m2 = 1'b0; m_lockreg = 1'b0;
      return;
    end
    lk = m2;  // lock as seen by the FSM: raw input sampled two edges back
    m_lockreg = lk & ~rb_cont_cal;
    nm = mode;
    if (!cal_start) begin
      nm = M_IDLE;
      m_retry = 2'd0;
    end else begin
      case (mode)
        M_IDLE: begin nm = M_RST; m_retry = 2'd0; end
        M_RST: if (cyc - t_enter == 4) nm = M_WAIT;
        M_WAIT: begin
          if (lk) nm = M_SETTLE;
          else if (rb_lock_tmo != 0 && cyc - t_enter == int'(rb_lock_tmo) + 1) begin
            if (m_retry == rb_max_retry) nm = M_FAIL;
            else begin m_retry = m_retry + 2'd1; nm = M_RST; end
          end
        end
        M_SETTLE: begin
          if (!lk) nm = M_WAIT;
          else if (cyc - t_enter == int'(rb_settle_dly) + 1) nm = M_DONE;
        end
        M_DONE: if (!lk && !rb_cont_cal) nm = M_WAIT;
        default: ;
      endcase
    end
    if (nm != mode) t_enter = cyc;
    mode = nm;
    m2 = m1;
    m1 = dll_lock_mux;
  endtask

  function automatic logic [31:0] expected();
    logic rstn, done, fl, bz;
    rstn = (mode == M_WAIT) || (mode == M_SETTLE) || (mode == M_DONE);
    done = (mode == M_DONE);
    fl   = (mode == M_FAIL);
    bz   = (mode == M_RST) || (mode == M_WAIT) || (mode == M_SETTLE);
    return {25'd0, rstn, done, m_lockreg, fl, bz, m_retry};
  endfunction

  task automatic step();
    @(posedge clk_dcd);
    model_edge();
    #1;
    check("outs", {25'd0, dll_rst_n, dcc_done, dll_lock_reg, cal_fail, busy, retry_cnt}, expected());
  endtask

  task automatic wait_rstn_up(input string tag);
    for (int i = 0; i < 40 && !dll_rst_n; i++) step();
    check(tag, {31'd0, dll_rst_n}, 32'd1);
  endtask

  task automatic restart();
    cal_start = 1'b0;
    step();
    cal_start = 1'b1;
  endtask

  initial begin
    int k, pulses, rst_cyc, seg, len;
    logic prev_in_rst, in_rst;

    // Reset held with request and lock asserted.
    cal_start = 1'b1;
    dll_lock_mux = 1'b1;
    repeat (3) step();
    check("reset_outs", {25'd0, dll_rst_n, dcc_done, dll_lock_reg, cal_fail, busy, retry_cnt}, 32'd0);
    RSTb = 1'b1;
    dll_lock_mux = 1'b0;
    step();
    check("rst_exit", {30'd0, busy, dll_rst_n}, 32'd2);

    // Nominal lock-to-done latency.
    rb_settle_dly = 4'd6; rb_lock_tmo = 12'd100; rb_max_retry = 2'd0;
    restart();
    wait_rstn_up("nom_rstn");
    repeat (19) step();
    dll_lock_mux = 1'b1;
    k = 0;
    do begin step(); k++; end while (!dcc_done && k < 40);
    check("lock2done", k - 1, 9);
    check("busy_at_done", {31'd0, busy}, 32'd0);

    // Lock loss in DONE with continuous mode off.
    dll_lock_mux = 1'b0;
    k = 0;
    do begin step(); k++; end while (dcc_done && k < 20);
    check("loss_fall", k, 3);

    // Continuous mode masks lock loss and forces dll_lock_reg low.
    dll_lock_mux = 1'b1;
    for (int i = 0; i < 40 && !dcc_done; i++) step();
    check("cont_done", {31'd0, dcc_done}, 32'd1);
    rb_cont_cal = 1'b1;
    step();
    dll_lock_mux = 1'b0;
    repeat (20) step();
    check("cont_hold", {30'd0, dcc_done, dll_lock_reg}, 32'd2);
    rb_cont_cal = 1'b0;

    // Retry then fail: three 4-cycle DLL reset pulses.
    rb_lock_tmo = 12'd10; rb_max_retry = 2'd2;
    restart();
    pulses = 0; rst_cyc = 0; prev_in_rst = 1'b0;
    for (int i = 0; i < 200 && !cal_fail; i++) begin
      step();
      in_rst = busy & ~dll_rst_n;
      if (in_rst) rst_cyc++;
      if (in_rst && !prev_in_rst) pulses++;
      prev_in_rst = in_rst;
    end
    check("fail_set", {31'd0, cal_fail}, 32'd1);
    check("fail_pulses", pulses, 3);
    check("fail_rst_cyc", rst_cyc, 12);
    check("fail_retry", {30'd0, retry_cnt}, 32'd2);
    repeat (5) step();
    check("fail_sticky", {30'd0, cal_fail, dll_rst_n}, 32'd2);
    cal_start = 1'b0;
    step();
    check("fail_clear", {25'd0, dll_rst_n, dcc_done, dll_lock_reg, cal_fail, busy, retry_cnt}, 32'd0);

    // Settle glitch: one low sample during SETTLE restarts the wait.
    rb_settle_dly = 4'd6; rb_lock_tmo = 12'd0;
    cal_start = 1'b1;
    wait_rstn_up("glitch_rstn");
    dll_lock_mux = 1'b1;
    repeat (5) step();
    dll_lock_mux = 1'b0;
    step();
    dll_lock_mux = 1'b1;
    k = 0;
    do begin step(); k++; end while (!dcc_done && k < 40);
    check("glitch_done", k, 10);

    // Lock and timeout on the same edge: lock wins.
    dll_lock_mux = 1'b0;
    rb_lock_tmo = 12'd10; rb_max_retry = 2'd2;
    restart();
    wait_rstn_up("tie_rstn");
    repeat (8) step();
    dll_lock_mux = 1'b1;
    repeat (3) step();
    check("lock_vs_tmo", {29'd0, dll_rst_n, retry_cnt}, 32'd4);

    // Abort while in SETTLE returns to IDLE on the next edge.
    step();
    cal_start = 1'b0;
    step();
    check("abort_settle", {28'd0, dll_rst_n, dcc_done, cal_fail, busy}, 32'd0);

    // Timeout disabled: never fails.
    dll_lock_mux = 1'b0;
    rb_lock_tmo = 12'd0;
    cal_start = 1'b1;
    repeat (5000) step();
    check("no_tmo", {29'd0, cal_fail, busy, dll_rst_n}, 32'd3);

    // Random scenarios against the model.
    for (int s = 0; s < 30; s++) begin
      cal_start = 1'b0;
      step();
      rb_settle_dly = 4'($urandom_range(0, 15));
      rb_lock_tmo   = ($urandom_range(0, 4) == 0) ? 12'd0 : 12'($urandom_range(1, 30));
      rb_max_retry  = 2'($urandom_range(0, 3));
      rb_cont_cal   = 1'($urandom_range(0, 1));
      dll_lock_mux  = 1'b0;
      cal_start     = 1'b1;
      seg = $urandom_range(1, 40);
      len = $urandom_range(150, 400);
      for (int c = 0; c < len; c++) begin
        step();
        seg = seg - 1;
        if (seg == 0) begin
          dll_lock_mux = ~dll_lock_mux;
          seg = dll_lock_mux ? $urandom_range(1, 60) : $urandom_range(1, 40);
        end
        cal_start = ($urandom_range(0, 199) != 0);
        if ($urandom_range(0, 99) == 0) rb_cont_cal = ~rb_cont_cal;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/aibcr3_dll_cal_seq.md
# aibcr3_dll_cal_seq

DLL lock / DCC calibration sequencer in the `clk_dcd` domain. It replaces a fixed flop-chain lock delay with a controlled sequence:
- hold the DLL in reset, then release it
- wait for lock, with a programmable timeout and bounded retries
- require a programmable settle interval of continuous lock
- assert `dcc_done`; in continuous-calibration mode, mask lock loss after done.

It sits between the DLL lock indicator and the DCC/lock consumers in the AIB calibration path.

## Interface
- `LOCK_TMO_W`, 12: width of the lock-timeout counter and of `rb_lock_tmo`.
- `SETTLE_W`, 4: width of the settle counter and of `rb_settle_dly`.
- `RETRY_W`, 2: width of the retry counter, `rb_max_retry` and `retry_cnt`.
- `clk_dcd`  in  1  sole clock.
- `RSTb`  in  1  reset; synchronous, active-low.
- `cal_start`  in  1  level request. High starts or holds calibration; low aborts it.
- `dll_lock_mux`  in  1  raw DLL lock, asynchronous to `clk_dcd`.
- `rb_cont_cal`  in  1  continuous-calibration mode.
- `rb_settle_dly`  in  SETTLE_W  extra settle cycles of stable lock before done.
- `rb_lock_tmo`  in  LOCK_TMO_W  lock timeout in cycles; 0 = no timeout.
- `rb_max_retry`  in  RETRY_W  DLL reset retries allowed before fail.
- `dll_rst_n`  out  1  DLL reset, active-low.
- `dcc_done`  out  1  calibration complete.
- `dll_lock_reg`  out  1  synchronized lock, forced 0 while `rb_cont_cal`=1.
- `cal_fail`  out  1  sticky failure flag.
- `retry_cnt`  out  RETRY_W  retries consumed.
- `busy`  out  1  high in DLL_RST, WAIT_LOCK and SETTLE.

## Operation
- **Synchronizer:** `dll_lock_mux` passes through 2 flops to produce `lock_s`.
- **State machine:** states IDLE, DLL_RST, WAIT_LOCK, SETTLE, DONE, FAIL.
- **Abort:** in any state, `cal_start`=0 forces IDLE on the next edge and clears `retry_cnt`, the timer and the settle counter. Abort has priority over every other transition.
- **IDLE:** `cal_start`=1 → DLL_RST, with `retry_cnt`=0.
- **DLL_RST:** holds `dll_rst_n`=0 for exactly `DLL_RST_CYC`=4 cycles, then → WAIT_LOCK with timer=0.
- **WAIT_LOCK:** the timer increments every cycle.
  - `lock_s`=1 → SETTLE with settle count=0.
  - Otherwise, if `rb_lock_tmo`≠0 and timer==`rb_lock_tmo`:
    - `retry_cnt`==`rb_max_retry` → FAIL.
    - Else `retry_cnt`+1 → DLL_RST.
  - Lock and timeout in the same cycle: lock wins.
- **SETTLE:**
  - `lock_s`=0 → WAIT_LOCK, timer reset to 0, `retry_cnt` unchanged.
  - Else, count==`rb_settle_dly` → DONE.
  - Else count+1.
- **DONE:** `dcc_done`=1.
  - `lock_s`=0 and `rb_cont_cal`=0 → WAIT_LOCK with timer=0.
  - `lock_s`=0 and `rb_cont_cal`=1: lock loss ignored, stay in DONE.
- **FAIL:** `cal_fail`=1 and `dll_rst_n`=0. Exit only through abort.
- **Counters:** `retry_cnt` saturates by construction and never wraps. The timer is compared by equality only and is cleared on every entry to WAIT_LOCK.

## Timing
- **Reset values:** state IDLE; `dll_rst_n`=0, `dcc_done`=0, `dll_lock_reg`=0, `cal_fail`=0, `retry_cnt`=0, `busy`=0. Synchronizer flops also cleared.
- **Outputs:** all registered, decoded from next-state. No combinational input-to-output paths.
- **`dll_rst_n`:** high only in WAIT_LOCK, SETTLE and DONE.
- **Lock-to-done latency:** with `dll_lock_mux` first sampled high at edge e:
  - `lock_s` high at e+1.
  - SETTLE at e+2.
  - DONE (and `dcc_done`=1) at e+3+`rb_settle_dly`.
- **Lock loss in DONE** (`rb_cont_cal`=0): `dcc_done` falls at e+2.
- **`dll_lock_reg`:** equals `lock_s` & ~`rb_cont_cal`, registered, so it lags `lock_s` by 1 cycle.
- **Timeout:** from WAIT_LOCK entry, with no lock, the timeout fires `rb_lock_tmo`+1 cycles later. A full retry period is 4 + `rb_lock_tmo` + 1 cycles.
- **Register changes:** `rb_*` changes take effect on the next comparison. Changing `rb_settle_dly` mid-SETTLE compares against the new value. If the count already exceeds the new value, the block waits for wrap-free equality; software must program `rb_settle_dly` only when `busy`=0.

## Structure
- **Package `aibcr3_dll_cal_pkg`:** state enum, `DLL_RST_CYC`=4, and the default widths.
- **Sub-module `aibcr3_dll_lock_sync`:** 2-flop synchronizer with synchronous active-low clear, instantiated once for `dll_lock_mux`.
- **Remainder:** one FSM with the timer, settle counter and retry counter.

## Test plan
- **Reset:** hold `RSTb`=0 for 3 cycles with `cal_start`=1 and `dll_lock_mux`=1 → all outputs 0, state IDLE. After release, DLL_RST is entered on the first edge.
- **Nominal:** `rb_settle_dly`=6, `rb_lock_tmo`=100; lock rises 20 cycles after `dll_rst_n`↑ → `dcc_done`=1 exactly 9 edges after the first high sample; `busy` falls on the same edge.
- **Retry/fail:** `rb_lock_tmo`=10, `rb_max_retry`=2, lock never asserts → 3 `dll_rst_n` low pulses of 4 cycles each, `retry_cnt` 0→1→2, then `cal_fail`=1. `cal_fail` holds until `cal_start`=0, then all outputs clear next cycle.
- **Settle glitch:** lock drops for 1 cycle at settle count 3 → return to WAIT_LOCK, timer restarts, `dcc_done` stays 0. Done asserts a full settle later.
- **Continuous mode:** in DONE, drop lock.
  - `rb_cont_cal`=0 → `dcc_done` falls 2 cycles later.
  - `rb_cont_cal`=1 → `dcc_done` stays 1 and `dll_lock_reg`=0 throughout.
- **Corners:** lock and timeout on the same cycle → SETTLE. `rb_lock_tmo`=0 → never times out over 5000 cycles. `cal_start`↓ in SETTLE → IDLE next edge.
